// File: rtl/threshold_reporter.sv
// threshold_reporter
//   Reports the signed trigger threshold over a UART byte stream as an ASCII
//   line "T=<sign><hex digits>\r\n". A report is sent once after reset, each
//   time the threshold changes, and on an explicit request. Triggers that
//   arrive while a report is already owed collapse into one report.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   threshold   signed (two's complement) threshold value, N_P bits
//   report_req  single-cycle request to report the current value
//   tx_data     ASCII byte to the UART transmitter
//   tx_valid    tx_data is valid (held until accepted)
//   tx_ready    transmitter accepts the byte when tx_valid & tx_ready
//   busy        high while a message is being sent
module threshold_reporter #(
  parameter int N_P = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N_P-1:0] threshold,
  input  logic           report_req,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy
);

  localparam int ND = (N_P + 3) / 4;   // hex digits of the magnitude
  localparam int L  = ND + 5;          // message length in bytes
  localparam int IW = $clog2(L);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [N_P-1:0] snap, snap_n;
  logic [N_P-1:0] thr_q;
  logic           pending, pending_n;
  logic           pend_clr;
  logic           trig;

  logic [N_P-1:0]  mag;
  logic [4*ND-1:0] mag_ext;
  logic [7:0]      cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // A new trigger always wins over the clear performed at message capture,
  // so at most one extra message follows the one being started.
  assign trig      = (threshold != thr_q) | report_req;
  assign pending_n = trig | (pending & ~pend_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      thr_q   <= threshold;
      pending <= 1'b1;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      snap    <= snap_n;
      thr_q   <= threshold;
      pending <= pending_n;
    end
  end

  // Magnitude as an N_P-bit unsigned value: the most negative input
  // negates to itself, which read unsigned is exactly 2^(N_P-1).
  always_comb begin
    mag     = snap[N_P-1] ? (~snap + 1'b1) : snap;
    mag_ext = (4*ND)'(mag);
  end

  always_comb begin
    cur_byte = 8'h0A;
    for (int unsigned k = 0; k < ND; k++) begin
      if (idx == IW'(3 + k))
        cur_byte = hex_char(mag_ext[4*(ND-1-k) +: 4]);
    end
    if (idx == IW'(0))        cur_byte = 8'h54;
    else if (idx == IW'(1))   cur_byte = 8'h3D;
    else if (idx == IW'(2))   cur_byte = snap[N_P-1] ? 8'h2D : 8'h2B;
    else if (idx == IW'(L-2)) cur_byte = 8'h0D;
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    snap_n   = snap;
    pend_clr = 1'b0;
    busy     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_n  = SEND;
          snap_n   = threshold;
          idx_n    = '0;
          pend_clr = 1'b1;
        end
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          if (idx == IW'(L-1)) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_threshold_reporter.sv
module tb_threshold_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] threshold;
  logic        report_req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  threshold_reporter #(.N_P(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .threshold  (threshold),
    .report_req (report_req),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         hs_count = 0;
  int         hs_cyc[256];
  int         cyc = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  bit         bp_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction

  // Push the first n bytes of the expected line for value v.
  task automatic push_msg(input int v, input int n);
    logic [7:0] b[8];
    int m;
    m = (v < 0) ? -v : v;
    b[0] = 8'h54; b[1] = 8'h3D;
    b[2] = (v < 0) ? 8'h2D : 8'h2B;
    b[3] = hexc((m >> 8) & 15);
    b[4] = hexc((m >> 4) & 15);
    b[5] = hexc(m & 15);
    b[6] = 8'h0D; b[7] = 8'h0A;
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
  endtask

  // Monitor: sample away from the active edge; a byte seen valid & ready
  // here is accepted at the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hold) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(tx_valid), 32'd0);
        else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        if (hs_count < 256) hs_cyc[hs_count] = cyc;
        hs_count++;
      end
    end
    prev_hold = !reset && tx_valid && !tx_ready;
    prev_data = tx_data;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      if (bp_en) tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    tx_ready = 1'b1;
    bp_en    = 1'b0;
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 200) begin
      tick();
      n++;
    end
    check("hs_reached", 32'(hs_count >= target), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1; threshold = 12'd10; report_req = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 1: reset value reported once
    push_msg(10, 8);
    reset = 1'b0;
    wait_idle(100);
    repeat (5) tick();

    // 2: value formats
    push_msg(-1, 8);
    threshold = 12'hFFF; report_req = 1'b1; tick(); report_req = 1'b0;
    wait_idle(100);
    push_msg(-2048, 8);
    threshold = 12'h800;
    wait_idle(100);
    push_msg(2047, 8);
    threshold = 12'h7FF;
    wait_idle(100);
    push_msg(2047, 8);
    report_req = 1'b1; tick(); report_req = 1'b0;
    wait_idle(100);

    // 3: random backpressure
    push_msg(291, 8);
    threshold = 12'd291; bp_en = 1'b1;
    wait_idle(500);

    // 4: change during flight, follow-up after a one-cycle gap
    threshold = 12'd10;
    push_msg(10, 8);
    wait_idle(100);
    base = hs_count;
    push_msg(10, 8);
    report_req = 1'b1; tick(); report_req = 1'b0;
    wait_hs(base + 3);
    threshold = 12'd11;
    push_msg(11, 8);
    wait_idle(100);
    check("gap_cycles", 32'(hs_cyc[(base + 8) % 256] - hs_cyc[(base + 7) % 256]), 32'd2);
    check("byte_count", 32'(hs_count - base), 32'd16);

    // 5: many triggers during one message coalesce to one follow-up
    push_msg(11, 8);
    report_req = 1'b1; tick(); report_req = 1'b0;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    check("msg5_started", 32'(busy), 32'd1);
    threshold = 12'd20; tick();
    report_req = 1'b1; tick(); report_req = 1'b0;
    threshold = 12'd30; tick();
    report_req = 1'b1; tick(); report_req = 1'b0;
    threshold = -12'sd5; tick();
    check("msg5_inflight", 32'(busy), 32'd1);
    push_msg(-5, 8);
    wait_idle(100);
    repeat (20) tick();

    // 6: reset after the 4th byte abandons the message
    base = hs_count;
    push_msg(-5, 4);
    report_req = 1'b1; tick(); report_req = 1'b0;
    wait_hs(base + 4);
    reset = 1'b1; tx_ready = 1'b0; threshold = 12'd77;
    tick();
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("partial_bytes", 32'(hs_count - base), 32'd4);
    push_msg(77, 8);
    reset = 1'b0; tx_ready = 1'b1;
    wait_idle(100);
    repeat (10) tick();
    check("final_bytes", 32'(hs_count - base), 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/threshold_reporter.md
Name: threshold_reporter

Overview:
- Reads the signed trigger threshold produced by the button/switch threshold controller and reports it over the UART as a fixed-length ASCII line.
- Sits between the threshold register and the UART transmitter byte interface.
- Sends one report after reset, whenever the threshold changes, and on explicit request, so the host always sees the current discriminator level.

Parameters:
N_P, 12, width of the signed threshold input (two's complement); must be at least 4.
ND, (N_P+3)/4, derived constant: number of hex digits for the magnitude. Not overridable.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
threshold  input  N_P  signed threshold value to report
report_req  input  1  single-cycle pulse requesting a report of the current value
tx_data  output  8  ASCII byte to the UART transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  transmitter accepts the byte when tx_valid and tx_ready are both high
busy  output  1  high while a message is being sent

Behaviour:
- Clock domain and reset: clk only. reset is synchronous, active-high.
- Outputs on reset: tx_valid=0, tx_data=8'h00, busy=0. Internal thr_q is loaded with the current threshold, pending=1 and byte index=0. As a result, the reset value is always reported once reset is released.
- Message format (length L = ND+5 bytes, sent in this order):
  - 'T' (0x54), then '=' (0x3D).
  - Sign: '+' (0x2B) if snapshot >= 0, else '-' (0x2D).
  - ND uppercase hex digits of the magnitude, MSB first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - CR (0x0D), then LF (0x0A).
- Magnitude: the N_P-bit unsigned value of the snapshot if non-negative, else of its two's-complement negation.
  - Most negative value: -2^(N_P-1) gives magnitude 2^(N_P-1); for N_P=12 this reports "-800". No overflow is allowed.
  - The magnitude is zero-extended to 4*ND bits before digit extraction.
- Change detection:
  - thr_q registers threshold every cycle.
  - threshold != thr_q sets pending.
  - A report_req pulse also sets pending.
  - Repeated triggers while pending is already set coalesce into a single report.
- State machine:
  - IDLE: busy=0, tx_valid=0. If pending=1, go to SEND on the next edge, capture the snapshot from the current threshold input, clear pending and set index=0.
  - SEND: busy=1, tx_valid=1, tx_data=byte[index] derived from the snapshot.
    - On a handshake (tx_valid & tx_ready), increment index.
    - After the handshake of byte L-1, return to IDLE; tx_valid drops the following cycle.
  - Without tx_ready, tx_valid and tx_data stay constant (AXI-stream style hold rule). tx_valid never depends combinationally on tx_ready.
- Snapshot stability: changes of threshold during SEND do not alter the message in flight. They set pending, and a new full message follows after LF.
- Simultaneous events:
  - A change or report_req in the same cycle as the IDLE->SEND capture still sets pending; the set wins over the clear.
  - Consequence: at most one extra message follows.
- Throughput: with tx_ready held high, one byte per cycle, L cycles per message. The IDLE gap between back-to-back messages is exactly 1 cycle.
- Reset mid-message: the message is abandoned immediately with no trailing bytes. After reset a fresh complete message of the then-current value is sent.

Test Plan:
1. Reset with threshold=10, tx_ready=1 -> after reset release, exactly bytes 54 3D 2B 30 30 41 0D 0A ("T=+00A\r\n"), then idle with busy=0.
2. threshold=-1 then report_req pulse -> "T=-001\r\n". threshold=-2048 -> "T=-800\r\n". threshold=2047 -> "T=+7FF\r\n".
3. Backpressure: tx_ready toggles randomly, 50% duty -> each byte held stable while valid and not ready; byte order and count (8) exact; no byte duplicated or dropped.
4. Change threshold 10->11 at byte 3 of an in-flight message -> current message still "+00A". Immediately afterwards, after a 1-cycle gap, "T=+00B\r\n".
5. Three threshold changes and two report_req pulses during one message -> exactly one follow-up message, carrying the final value.
6. Assert reset after byte 4 handshake -> tx_valid=0 the next cycle. After release, a complete 8-byte message with the current threshold is sent; no partial tail appears.
